// File: rtl/vertex_cl_packer_pkg.sv
// Shared vertex types and conversions for vertex write-back.
// A vertex packs into the low 50 bits of a 64-bit word; bits 63:50 are zero.
package vertex_cl_packer_pkg;

    localparam int unsigned SLOTS    = 8;
    localparam int unsigned WORD_W   = 64;
    localparam int unsigned VERTEX_W = 50;
    localparam int unsigned LINE_W   = SLOTS * WORD_W;

    typedef struct packed {
        logic [1:0]  kind;
        logic [15:0] edge_ptr;
        logic [31:0] value;
    } vertex_t;

    function automatic vertex_t int64_to_vertex(input logic [WORD_W-1:0] word);
        return vertex_t'(word[VERTEX_W-1:0]);
    endfunction

    function automatic logic [WORD_W-1:0] vertex_to_int64(input vertex_t v);
        return {{(WORD_W - VERTEX_W){1'b0}}, v};
    endfunction

endpackage

// File: rtl/vertex_cl_packer.sv
// Vertex-to-cacheline packer.
// Gathers vertices whose addresses share a cacheline index into one accumulator and emits
// the line (data, index, slot mask) through a valid/ready output register. A new line index,
// a full accumulator or a flush request causes the accumulator to be emitted.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   vertex_in/addr       vertex and its address (addr[2:0] = slot, upper bits = line)
//   vertex_valid/ready   input handshake
//   flush                single-cycle request to emit the partial line
//   cl_out/addr/mask     emitted line, line index, written-slot mask
//   cl_valid/ready       output handshake
//   idle                 accumulator empty, no line pending, no flush pending
module vertex_cl_packer
    import vertex_cl_packer_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  vertex_t           vertex_in,
    input  logic [ADDR_W-1:0] vertex_addr,
    input  logic              vertex_valid,
    output logic              vertex_ready,
    input  logic              flush,
    output logic [511:0]      cl_out,
    output logic [ADDR_W-4:0] cl_addr,
    output logic [7:0]        cl_mask,
    output logic              cl_valid,
    input  logic              cl_ready,
    output logic              idle
);

    typedef enum logic [1:0] {StEmpty, StFill, StFull, StFlush} state_e;

    state_e state_q, state_d;

    logic [WORD_W-1:0] acc_data [SLOTS];
    logic [7:0]        acc_mask_q, acc_mask_d;
    logic [ADDR_W-4:0] acc_line_q, acc_line_d;

    logic [ADDR_W-4:0] line_in;
    logic [2:0]        slot_in;
    logic [7:0]        slot_bit;
    logic              line_match;
    logic              out_free;
    logic              ready_state;
    logic              accept;
    logic              emit;
    logic [LINE_W-1:0] line_packed;

    assign line_in    = vertex_addr[ADDR_W-1:3];
    assign slot_in    = vertex_addr[2:0];
    assign slot_bit   = 8'b1 << slot_in;
    assign line_match = (acc_line_q == line_in);
    assign out_free   = !cl_valid || cl_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a new flush request wins; a pending flush holds until the partial
    // line leaves; otherwise the state follows the next accumulator mask.
    always_comb begin
        state_d = state_q;
        if (state_q != StFlush && flush) begin
            state_d = StFlush;
        end else if (state_q == StFlush && acc_mask_q != 8'h00 && !out_free) begin
            state_d = StFlush;
        end else if (acc_mask_d == 8'h00) begin
            state_d = StEmpty;
        end else if (acc_mask_d == 8'hFF) begin
            state_d = StFull;
        end else begin
            state_d = StFill;
        end
    end

    // Outputs: ready never looks at vertex_valid; flush blocks acceptance in its cycle.
    always_comb begin
        ready_state = 1'b0;
        emit        = 1'b0;
        case (state_q)
            StEmpty: ready_state = 1'b1;
            StFill: begin
                ready_state = line_match || out_free;
                emit        = accept && !line_match;
            end
            StFull: begin
                ready_state = out_free;
                emit        = out_free && !flush;
            end
            StFlush: begin
                ready_state = 1'b0;
                emit        = out_free && (acc_mask_q != 8'h00);
            end
            default: begin
                ready_state = 1'b0;
                emit        = 1'b0;
            end
        endcase
    end

    assign vertex_ready = rst_n && !flush && ready_state;
    assign accept       = vertex_valid && vertex_ready;
    assign idle         = (acc_mask_q == 8'h00) && !cl_valid && (state_q != StFlush);

    // Accumulator mask and line: an emit clears, an accepted vertex then adds its slot,
    // so emit-and-reload happens in one edge.
    always_comb begin
        acc_mask_d = acc_mask_q;
        acc_line_d = acc_line_q;
        if (emit) begin
            acc_mask_d = 8'h00;
        end
        if (accept) begin
            acc_mask_d = acc_mask_d | slot_bit;
            acc_line_d = line_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_mask_q <= 8'h00;
            acc_line_q <= '0;
        end else begin
            acc_mask_q <= acc_mask_d;
            acc_line_q <= acc_line_d;
        end
    end

    // Slot storage; validity lives in acc_mask so data needs no reset.
    for (genvar i = 0; i < SLOTS; i++) begin : g_slot
        always_ff @(posedge clk) begin
            if (accept && slot_in == 3'(i)) begin
                acc_data[i] <= vertex_to_int64(vertex_in);
            end
        end
    end

    // Unwritten slots go out as zero rather than stale data.
    always_comb begin
        line_packed = '0;
        for (int i = 0; i < SLOTS; i++) begin
            if (acc_mask_q[i]) begin
                line_packed[i*WORD_W +: WORD_W] = acc_data[i];
            end
        end
    end

    // Output register: loads only when out_free, so it is stable while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cl_valid <= 1'b0;
            cl_mask  <= 8'h00;
            cl_addr  <= '0;
            cl_out   <= '0;
        end else if (emit) begin
            cl_valid <= 1'b1;
            cl_mask  <= acc_mask_q;
            cl_addr  <= acc_line_q;
            cl_out   <= line_packed;
        end else if (cl_ready) begin
            cl_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vertex_cl_packer.sv
module tb_vertex_cl_packer;
    import vertex_cl_packer_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    vertex_t      vertex_in;
    logic [7:0]   vertex_addr;
    logic         vertex_valid;
    logic         vertex_ready;
    logic         flush;
    logic [511:0] cl_out;
    logic [4:0]   cl_addr;
    logic [7:0]   cl_mask;
    logic         cl_valid;
    logic         cl_ready;
    logic         idle;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    vertex_cl_packer #(.ADDR_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .vertex_in    (vertex_in),
        .vertex_addr  (vertex_addr),
        .vertex_valid (vertex_valid),
        .vertex_ready (vertex_ready),
        .flush        (flush),
        .cl_out       (cl_out),
        .cl_addr      (cl_addr),
        .cl_mask      (cl_mask),
        .cl_valid     (cl_valid),
        .cl_ready     (cl_ready),
        .idle         (idle)
    );

    // Distinct 50-bit vertex pattern per index, with bit 49 set for some indices.
    function automatic logic [49:0] raw_v(input int i);
        logic [1:0] k;
        k = 2'(i) ^ 2'b10;
        return {k, 16'h1000 + 16'(i), 32'hA500_0000 + 32'(i)};
    endfunction

    function automatic logic [63:0] exp_word(input int i);
        return {14'd0, raw_v(i)};
    endfunction

    task automatic push(input logic [7:0] a, input int idx);
        int n;
        vertex_addr  = a;
        vertex_in    = vertex_t'(raw_v(idx));
        vertex_valid = 1'b1;
        #1;
        n = 0;
        while (!vertex_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n == 100) begin
            tests++; fails++;
            $display("FAIL push_timeout addr=%h: vertex_ready stayed 0, want 1", a);
        end
        @(posedge clk); #1;
        vertex_valid = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        tests++; if (cl_valid !== 1'b0) begin fails++; $display("FAIL rst_cl_valid: got %b want 0", cl_valid); end
        tests++; if (cl_mask !== 8'h00) begin fails++; $display("FAIL rst_cl_mask: got %h want 00", cl_mask); end
        tests++; if (cl_addr !== 5'd0) begin fails++; $display("FAIL rst_cl_addr: got %h want 0", cl_addr); end
        tests++; if (cl_out !== 512'd0) begin fails++; $display("FAIL rst_cl_out: got nonzero want 0"); end
        tests++; if (vertex_ready !== 1'b0) begin fails++; $display("FAIL rst_ready: got %b want 0", vertex_ready); end
        tests++; if (idle !== 1'b1) begin fails++; $display("FAIL rst_idle: got %b want 1", idle); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests++; if (vertex_ready !== 1'b1) begin fails++; $display("FAIL rst_release_ready: got %b want 1", vertex_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_full_line();
        for (int i = 0; i < 8; i++) push(8'h10 + 8'(i), i);
        tests++; if (cl_valid !== 1'b0) begin fails++; $display("FAIL full_early_valid: got %b want 0", cl_valid); end
        @(posedge clk); #1;
        tests++; if (cl_valid !== 1'b1) begin fails++; $display("FAIL full_valid: got %b want 1", cl_valid); end
        tests++; if (cl_addr !== 5'd2) begin fails++; $display("FAIL full_addr: got %h want 2", cl_addr); end
        tests++; if (cl_mask !== 8'hFF) begin fails++; $display("FAIL full_mask: got %h want ff", cl_mask); end
        for (int s = 0; s < 8; s++) begin
            tests++;
            if (cl_out[s*64 +: 64] !== exp_word(s)) begin
                fails++;
                $display("FAIL full_slot%0d: got %h want %h", s, cl_out[s*64 +: 64], exp_word(s));
            end
        end
        @(posedge clk); #1;
        tests++; if (cl_valid !== 1'b0) begin fails++; $display("FAIL full_valid_clear: got %b want 0", cl_valid); end
    endtask

    task automatic test_line_switch();
        push(8'h21, 40);
        push(8'h48, 41);
        tests++; if (cl_valid !== 1'b1) begin fails++; $display("FAIL sw_valid: got %b want 1", cl_valid); end
        tests++; if (cl_addr !== 5'd4) begin fails++; $display("FAIL sw_addr: got %h want 4", cl_addr); end
        tests++; if (cl_mask !== 8'h02) begin fails++; $display("FAIL sw_mask: got %h want 02", cl_mask); end
        tests++; if (cl_out[64 +: 64] !== exp_word(40)) begin fails++; $display("FAIL sw_slot1: got %h want %h", cl_out[64 +: 64], exp_word(40)); end
        pulse_flush();
        @(posedge clk); #1;
        tests++; if (cl_addr !== 5'd9) begin fails++; $display("FAIL sw_acc_addr: got %h want 9", cl_addr); end
        tests++; if (cl_mask !== 8'h01) begin fails++; $display("FAIL sw_acc_mask: got %h want 01", cl_mask); end
        tests++; if (cl_out[0 +: 64] !== exp_word(41)) begin fails++; $display("FAIL sw_acc_slot0: got %h want %h", cl_out[0 +: 64], exp_word(41)); end
        @(posedge clk); #1;
        tests++; if (idle !== 1'b1) begin fails++; $display("FAIL sw_idle: got %b want 1", idle); end
    endtask

    task automatic test_backpressure();
        cl_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(8'h18 + 8'(i), 8 + i);
        for (int i = 0; i < 8; i++) push(8'h28 + 8'(i), 16 + i);
        repeat (3) begin @(posedge clk); #1; end
        tests++; if (vertex_ready !== 1'b0) begin fails++; $display("FAIL bp_ready: got %b want 0", vertex_ready); end
        tests++; if (cl_valid !== 1'b1) begin fails++; $display("FAIL bp_valid: got %b want 1", cl_valid); end
        tests++; if (cl_addr !== 5'd3) begin fails++; $display("FAIL bp_addr: got %h want 3", cl_addr); end
        tests++; if (cl_mask !== 8'hFF) begin fails++; $display("FAIL bp_mask: got %h want ff", cl_mask); end
        tests++; if (cl_out[7*64 +: 64] !== exp_word(15)) begin fails++; $display("FAIL bp_slot7: got %h want %h", cl_out[7*64 +: 64], exp_word(15)); end
        cl_ready = 1'b1;
        @(posedge clk); #1;
        tests++; if (cl_valid !== 1'b1) begin fails++; $display("FAIL bp_b2b_valid: got %b want 1", cl_valid); end
        tests++; if (cl_addr !== 5'd5) begin fails++; $display("FAIL bp_second_addr: got %h want 5", cl_addr); end
        tests++; if (cl_out[0 +: 64] !== exp_word(16)) begin fails++; $display("FAIL bp_second_slot0: got %h want %h", cl_out[0 +: 64], exp_word(16)); end
        @(posedge clk); #1;
        tests++; if (cl_valid !== 1'b0) begin fails++; $display("FAIL bp_drain: got %b want 0", cl_valid); end
    endtask

    task automatic test_dup_flush();
        push(8'h05, 50);
        push(8'h05, 51);
        pulse_flush();
        tests++; if (vertex_ready !== 1'b0) begin fails++; $display("FAIL dup_flush_ready: got %b want 0", vertex_ready); end
        @(posedge clk); #1;
        tests++; if (cl_mask !== 8'h20) begin fails++; $display("FAIL dup_mask: got %h want 20", cl_mask); end
        tests++; if (cl_addr !== 5'd0) begin fails++; $display("FAIL dup_addr: got %h want 0", cl_addr); end
        tests++; if (cl_out[5*64 +: 64] !== exp_word(51)) begin fails++; $display("FAIL dup_slot5: got %h want %h", cl_out[5*64 +: 64], exp_word(51)); end
        @(posedge clk); #1;
        tests++; if (idle !== 1'b1) begin fails++; $display("FAIL dup_idle: got %b want 1", idle); end
    endtask

    task automatic test_flush_priority();
        push(8'h30, 60);
        flush        = 1'b1;
        vertex_addr  = 8'h31;
        vertex_in    = vertex_t'(raw_v(61));
        vertex_valid = 1'b1;
        #1;
        tests++; if (vertex_ready !== 1'b0) begin fails++; $display("FAIL prio_ready_flush: got %b want 0", vertex_ready); end
        @(posedge clk); #1;
        flush = 1'b0;
        #1;
        tests++; if (vertex_ready !== 1'b0) begin fails++; $display("FAIL prio_ready_pending: got %b want 0", vertex_ready); end
        @(posedge clk); #1;
        tests++; if (cl_valid !== 1'b1) begin fails++; $display("FAIL prio_valid: got %b want 1", cl_valid); end
        tests++; if (cl_mask !== 8'h01) begin fails++; $display("FAIL prio_mask: got %h want 01", cl_mask); end
        tests++; if (cl_addr !== 5'd6) begin fails++; $display("FAIL prio_addr: got %h want 6", cl_addr); end
        tests++; if (vertex_ready !== 1'b1) begin fails++; $display("FAIL prio_retry_ready: got %b want 1", vertex_ready); end
        @(posedge clk); #1;
        vertex_valid = 1'b0;
        pulse_flush();
        @(posedge clk); #1;
        tests++; if (cl_mask !== 8'h02) begin fails++; $display("FAIL prio_retry_mask: got %h want 02", cl_mask); end
        tests++; if (cl_out[64 +: 64] !== exp_word(61)) begin fails++; $display("FAIL prio_retry_slot1: got %h want %h", cl_out[64 +: 64], exp_word(61)); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) push(8'h40 + 8'(i), 30 + i);
        tests++; if (idle !== 1'b0) begin fails++; $display("FAIL mid_busy: got idle %b want 0", idle); end
        rst_n = 1'b0;
        #1;
        tests++; if (vertex_ready !== 1'b0) begin fails++; $display("FAIL mid_rst_ready: got %b want 0", vertex_ready); end
        tests++; if (cl_valid !== 1'b0) begin fails++; $display("FAIL mid_rst_valid: got %b want 0", cl_valid); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests++; if (vertex_ready !== 1'b1) begin fails++; $display("FAIL mid_release_ready: got %b want 1", vertex_ready); end
        tests++; if (idle !== 1'b1) begin fails++; $display("FAIL mid_release_idle: got %b want 1", idle); end
        @(posedge clk); #1;
        pulse_flush();
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            tests++;
            if (cl_valid !== 1'b0) begin fails++; $display("FAIL mid_no_emit c%0d: got %b want 0", c, cl_valid); end
        end
        tests++; if (idle !== 1'b1) begin fails++; $display("FAIL mid_final_idle: got %b want 1", idle); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1);
    end

    initial begin
        cl_ready     = 1'b1;
        flush        = 1'b0;
        vertex_valid = 1'b0;
        vertex_addr  = 8'h00;
        vertex_in    = '0;
        test_reset();
        test_full_line();
        test_line_switch();
        test_backpressure();
        test_dup_flush();
        test_flush_priority();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vertex_cl_packer.md
VERTEX_CL_PACKER -- requirements
Module: vertex_cl_packer

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, giving the vertex address width; the cacheline index is ADDR_W-3 bits.
REQ-002 SHALL have port clk, input, 1 bit, the single clock.
REQ-003 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-004 SHALL have port vertex_in, input, vertex_t, the vertex to be written back.
REQ-005 SHALL have port vertex_addr, input, ADDR_W bits, the exact vertex address; bits [2:0] select the slot and bits [ADDR_W-1:3] select the line.
REQ-006 SHALL have port vertex_valid, input, 1 bit; a vertex transfers when vertex_valid and vertex_ready are both high at a clk edge.
REQ-007 SHALL have port vertex_ready, output, 1 bit.
REQ-008 SHALL have port flush, input, 1 bit, a single-cycle request to emit the partial line.
REQ-009 SHALL have port cl_out, output, 512 bits; slot i occupies [i*64+63:i*64], holding vertex_to_int64(v), where bits 63:50 are zero.
REQ-010 SHALL have port cl_addr, output, ADDR_W-3 bits, the line index.
REQ-011 SHALL have port cl_mask, output, 8 bits, with bit i set when slot i is written.
REQ-012 SHALL have port cl_valid, output, 1 bit, and port cl_ready, input, 1 bit; a line transfers when both are high at an edge.
REQ-013 SHALL have port idle, output, 1 bit, high when the accumulator is empty, cl_valid is low and no flush is pending.

Function
REQ-014 SHALL hold one accumulator (acc_data[8], acc_mask, acc_line) and one output register (cl_out, cl_addr, cl_mask, cl_valid).
REQ-015 SHALL define out_free = !cl_valid || cl_ready.
REQ-016 SHALL implement the states EMPTY (acc_mask==0), FILL (mask nonzero and not all ones), FULL (mask==8'hFF) and FLUSH (flush pending).
REQ-017 In EMPTY, vertex_ready SHALL be 1; an accepted vertex sets acc_line, the slot data and one mask bit, and the state goes to FILL or FULL.
REQ-018 In FILL with a matching line, vertex_ready SHALL be 1 and the accepted vertex SHALL write its slot; a duplicate slot overwrites (last write wins).
REQ-019 In FILL with a mismatching line, vertex_ready SHALL equal out_free; on acceptance the accumulator is emitted and reloaded with only the new vertex, in the same edge.
REQ-020 In FULL, the accumulator SHALL be emitted at the first edge with out_free; vertex_ready SHALL equal out_free, and a vertex accepted at that edge starts the new accumulator.
REQ-021 Emit SHALL copy acc_data, acc_line and acc_mask to the output register, set cl_valid, and clear or reload the accumulator.
REQ-022 Latency: for a completing vertex accepted at edge N with out_free true, cl_valid SHALL be high from edge N+1.
REQ-023 cl_out, cl_addr and cl_mask SHALL stay stable while cl_valid is high and cl_ready is low.
REQ-024 cl_valid SHALL clear when a line transfers and no emit occurs at the same edge; back-to-back emits SHALL keep cl_valid high.
REQ-025 On flush, the block SHALL enter FLUSH with vertex_ready forced to 0.
- If the accumulator is empty, FLUSH SHALL exit at the next edge.
- Otherwise the partial line SHALL be emitted at the first edge with out_free, and the block SHALL go to EMPTY.
REQ-026 flush SHALL have priority over vertex_valid in the same cycle: the vertex is not accepted.
REQ-027 A flush while FLUSH is already pending SHALL be ignored.
REQ-028 vertex_ready SHALL be combinational from state, line compare and cl_ready only, never from vertex_valid.

Reset
REQ-029 While rst_n is low, the block SHALL asynchronously set cl_valid=0, cl_mask=0, cl_addr=0, cl_out=0, acc_mask=0, state=EMPTY and flush pending=0.
REQ-030 Reset mid-operation SHALL discard any partial or unsent line without emitting it.
REQ-031 acc_data SHALL need no reset.
REQ-032 vertex_ready SHALL be 0 while rst_n is low and 1 in the first cycle after release.

Structure
REQ-033 vertex_t, int64_to_vertex and the new vertex_to_int64 SHALL live in the shared graph.vh package.
REQ-034 The state enum SHALL be local to the module.
REQ-035 The block SHALL be a single module with no sub-module; the slot write SHALL be a generate loop over 8 slots.

Verification
REQ-036 Scenario: 8 vertices at addr 0x10..0x17, cl_ready=1 -> one line with cl_addr=2, cl_mask=8'hFF, slot i = vertex i, cl_valid one edge after the 8th vertex.
REQ-037 Scenario: addr 0x21 then 0x48 -> line cl_addr=4, cl_mask=8'h02; the accumulator then holds line 9 with mask 8'h01.
REQ-038 Scenario: cl_ready held low with a full line pending -> the second line is stalled with vertex_ready=0, the output is stable; cl_ready=1 -> both lines delivered in order.
REQ-039 Scenario: addr 0x05 written twice (A then B), then flush -> cl_mask=8'h20, slot 5 = B, idle=1 after transfer.
REQ-040 Scenario: flush and vertex_valid in the same cycle -> the vertex is not accepted and is retried after FLUSH exits.
REQ-041 Scenario: rst_n low mid-fill with mask 8'h0F -> no line is emitted, cl_valid=0 and idle=1 after release.
